// File: rtl/data_mem_resp_if.sv
// Purpose: request/response bus between an initiator and the data_mem_resp
//          word memory.
// Signals:
//   req    - initiator requests an access this cycle
//   we     - 1 = write, 0 = read (qualified by req)
//   addr   - byte address of the access
//   wdata  - write data
//   ready  - memory accepts a request this cycle
//   rvalid - one-cycle completion pulse
//   rdata  - read data, valid with rvalid
//   err    - access failed (misaligned or out of range), valid with rvalid
interface data_mem_resp_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req;
  logic                 we;
  logic [BUS_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0] wdata;
  logic                 ready;
  logic                 rvalid;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Purpose: single-port word memory with a fixed access latency. One access
//          is in flight at a time; the request is captured when accepted in
//          IDLE, waits WAIT_CYCLES-1 cycles in BUSY, and completes with a
//          one-cycle rvalid pulse in RESP.
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset (clears state and every memory word)
//   bus - data_mem_resp_if slave modport (req/we/addr/wdata in,
//         ready/rvalid/rdata/err out)
module data_mem_resp #(
  parameter int BUS_WIDTH   = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_resp_if.slave   bus
);

  localparam int           IDX_W    = BUS_WIDTH - 2;
  localparam int           AW       = $clog2(MEM_DEPTH);
  localparam logic [3:0]   CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [3:0]             cnt_r;
  logic                   we_r;
  logic [BUS_WIDTH-1:0]   addr_r;
  logic [BUS_WIDTH-1:0]   wdata_r;
  logic [BUS_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic                   rvalid_r;
  logic                   err_r;
  logic [BUS_WIDTH-1:0]   rdata_r;

  logic                   accept_s;
  logic                   enter_resp_s;
  logic                   acc_we_s;
  logic [BUS_WIDTH-1:0]   acc_addr_s;
  logic [BUS_WIDTH-1:0]   acc_wdata_s;
  logic [IDX_W-1:0]       idx_s;
  logic [AW-1:0]          word_s;
  logic                   legal_s;

  assign accept_s     = (state_r == IDLE) && bus.req;
  assign enter_resp_s = (state_nxt_s == RESP);

  // Access attributes: with WAIT_CYCLES=1 RESP is entered on the accepting
  // edge itself, before the capture registers hold the request, so in IDLE
  // the live bus values are used instead.
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_we_s    = bus.we;
      acc_addr_s  = bus.addr;
      acc_wdata_s = bus.wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Address decode: word index, alignment and range check.
  always_comb begin
    idx_s   = acc_addr_s[BUS_WIDTH-1:2];
    word_s  = idx_s[AW-1:0];
    legal_s = (acc_addr_s[1:0] == 2'b00) && (idx_s < IDX_W'(MEM_DEPTH));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          state_nxt_s = (CNT_LOAD != 4'd0) ? BUSY : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // <= also covers a zero count so BUSY can never lock up
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: ready is forced low during reset so a req coincident
  // with rst is never seen as accepted.
  always_comb begin
    bus.ready  = (state_r == IDLE) && !rst;
    bus.rvalid = rvalid_r;
    bus.err    = err_r;
    bus.rdata  = rdata_r;
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cnt_r   <= CNT_LOAD;
        we_r    <= bus.we;
        addr_r  <= bus.addr;
        wdata_r <= bus.wdata;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Memory array: cleared by reset, written on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (enter_resp_s && acc_we_s && legal_s) begin
      mem_r[word_s] <= acc_wdata_s;
    end
  end

  // Response registers: non-zero only during the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= '0;
    end else if (enter_resp_s) begin
      rvalid_r <= 1'b1;
      err_r    <= !legal_s;
      rdata_r  <= (legal_s && !acc_we_s) ? mem_r[word_s] : '0;
    end else begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= '0;
    end
  end

endmodule
